// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: FU select encoding, default widths, null tag.
// Also holds the round-robin pointer advance rule used by the top.
package cdb_arbiter_pkg;

  typedef enum logic [1:0] {
    FU_ADDSUB = 2'd0,
    FU_MUL    = 2'd1,
    FU_DIV    = 2'd2
  } fu_sel_e;

  localparam int N_FU_DEF   = int'(FU_DIV) + 1;
  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;
  localparam int NULL_TAG   = 0;

  // Pointer moves one past the winner, wrapping at n-1 so non-power-of-two n never reaches n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping.
// Zero latency; outputs one-hot grant, encoded index and an any-grant flag.
module cdb_arbiter_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // First pass covers ptr..N-1; second pass catches the wrapped 0..ptr-1 segment.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        any_o    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter owning the common data bus: one FU result accepted per cycle, broadcast
// registered one cycle later; the bus itself never backpressures, only losing FUs wait.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int  N_FU   = N_FU_DEF,
  parameter int  TAG_W  = TAG_W_DEF,
  parameter int  DATA_W = DATA_W_DEF,
  localparam int SRC_W  = (N_FU > 1) ? $clog2(N_FU) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_FU-1:0]        req_valid,
  input  logic [N_FU*TAG_W-1:0]  req_tag,
  input  logic [N_FU*DATA_W-1:0] req_data,
  output logic [N_FU-1:0]        req_ready,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [DATA_W-1:0]      cdb_data,
  output logic [SRC_W-1:0]       cdb_src
);

  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [N_FU-1:0]   pick_gnt;
  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;
  logic              xfer;

  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

  cdb_arbiter_rr_pick #(
    .N     (N_FU),
    .IDX_W (SRC_W)
  ) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Nothing is accepted while rst is high, so held requests survive a reset cycle.
  assign req_ready = rst ? '0 : pick_gnt;
  assign xfer      = pick_any & ~rst;

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = xfer;
    cdb_tag_d   = '0;
    cdb_data_d  = '0;
    cdb_src_d   = '0;
    if (xfer) begin
      ptr_d     = SRC_W'(next_ptr(int'(pick_idx), N_FU));
      cdb_src_d = pick_idx;
      for (int i = 0; i < N_FU; i++) begin
        if (pick_gnt[i]) begin
          cdb_tag_d  = req_tag[i*TAG_W +: TAG_W];
          cdb_data_d = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Idle cycles zero tag/data/src so consumers can tag-match without qualifying on valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

  generate
    for (genvar g = 0; g < N_FU; g++) begin : g_tag_chk
      a_no_null_tag: assert property (@(posedge clk) disable iff (rst)
        req_valid[g] |-> (req_tag[g*TAG_W +: TAG_W] != TAG_W'(NULL_TAG)));
    end
  endgenerate

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

endmodule
